// File: rtl/branch_target_ctrl.sv
// Fetch-side branch controller: owns the IF PC, predicts the next PC from a direct-mapped
// BTB with 2-bit counters, and redirects fetch when the ID-stage resolution disagrees.
module branch_target_ctrl #(
    parameter int unsigned ENTRIES  = 16,
    parameter int unsigned IDX_W    = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    output logic [31:0] if_pc,
    output logic        flush,
    input  logic        id_valid,
    input  logic [31:0] id_pc,
    input  logic        id_is_cti,
    input  logic        id_taken,
    input  logic [31:0] id_target,
    output logic [31:0] br_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int unsigned TAG_W = 30 - IDX_W;

    logic             btb_valid  [ENTRIES];
    logic [TAG_W-1:0] btb_tag    [ENTRIES];
    logic [31:0]      btb_target [ENTRIES];
    logic [1:0]       btb_ctr    [ENTRIES];

    logic [31:0] pc_q;
    logic        pv_q;
    logic [31:0] pnext_q;
    logic [31:0] br_q;
    logic [31:0] mis_q;

    logic [IDX_W-1:0] if_idx;
    logic [TAG_W-1:0] if_tag;
    logic             if_hit;
    logic             pred_taken;
    logic [31:0]      pred_next;

    logic [IDX_W-1:0] id_idx;
    logic [TAG_W-1:0] id_tag;
    logic             id_hit;
    logic [1:0]       id_ctr;
    logic [31:0]      actual_next;
    logic             upd;
    logic             mispredict;

    logic       do_alloc;
    logic       do_inc;
    logic       do_dec;
    logic       do_inval;
    logic [1:0] ctr_new;

    // Lookup against the pre-edge table contents.
    assign if_idx     = pc_q[IDX_W+1:2];
    assign if_tag     = pc_q[31:IDX_W+2];
    assign if_hit     = btb_valid[if_idx] && (btb_tag[if_idx] == if_tag);
    assign pred_taken = if_hit && btb_ctr[if_idx][1];
    assign pred_next  = pred_taken ? btb_target[if_idx] : pc_q + 32'd4;

    assign id_idx      = id_pc[IDX_W+1:2];
    assign id_tag      = id_pc[31:IDX_W+2];
    assign id_hit      = btb_valid[id_idx] && (btb_tag[id_idx] == id_tag);
    assign id_ctr      = btb_ctr[id_idx];
    assign actual_next = id_taken ? id_target : id_pc + 32'd4;

    // A stalled cycle neither checks nor trains; ID inputs and pv are held for the next try.
    assign upd        = !stall && id_valid && pv_q;
    assign mispredict = upd && (actual_next != pnext_q);
    assign flush      = mispredict;

    assign if_pc       = pc_q;
    assign br_cnt      = br_q;
    assign mispred_cnt = mis_q;

    always_comb begin
        do_alloc = 1'b0;
        do_inc   = 1'b0;
        do_dec   = 1'b0;
        do_inval = 1'b0;
        if (upd) begin
            if (id_is_cti) begin
                if (id_hit) begin
                    do_inc = id_taken;
                    do_dec = !id_taken;
                end else begin
                    do_alloc = id_taken;
                end
            end else begin
                // Non-CTI hitting an entry means a stale or aliased prediction.
                do_inval = id_hit;
            end
        end
    end

    always_comb begin
        ctr_new = id_ctr;
        if (do_alloc) begin
            ctr_new = 2'b10;
        end else if (do_inc && id_ctr != 2'b11) begin
            ctr_new = id_ctr + 2'd1;
        end else if (do_dec && id_ctr != 2'b00) begin
            ctr_new = id_ctr - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                btb_valid[IDX_W'(i)]  <= 1'b0;
                btb_tag[IDX_W'(i)]    <= '0;
                btb_target[IDX_W'(i)] <= '0;
                btb_ctr[IDX_W'(i)]    <= 2'b01;
            end
        end else begin
            if (do_alloc) begin
                btb_valid[id_idx] <= 1'b1;
                btb_tag[id_idx]   <= id_tag;
            end else if (do_inval) begin
                btb_valid[id_idx] <= 1'b0;
            end
            if (do_alloc || (do_inc && id_taken)) begin
                btb_target[id_idx] <= id_target;
            end
            if (do_alloc || do_inc || do_dec) begin
                btb_ctr[id_idx] <= ctr_new;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            pv_q    <= 1'b0;
            pnext_q <= '0;
            br_q    <= '0;
            mis_q   <= '0;
        end else if (!stall) begin
            pc_q    <= mispredict ? actual_next : pred_next;
            // A flushed IF slot enters ID as a bubble.
            pv_q    <= !mispredict;
            pnext_q <= pred_next;
            if (upd && id_is_cti) begin
                br_q <= br_q + 32'd1;
            end
            if (mispredict) begin
                mis_q <= mis_q + 32'd1;
            end
        end
    end

endmodule

// File: tb/tb_branch_target_ctrl.sv
// Directed bench for branch_target_ctrl: the bench plays the ID stage and checks flush,
// next fetch PC and both counters against a queue of expected results.
module tb_branch_target_ctrl;

    logic        clk;
    logic        rst_n;
    logic        stall;
    logic [31:0] if_pc;
    logic        flush;
    logic        id_valid;
    logic [31:0] id_pc;
    logic        id_is_cti;
    logic        id_taken;
    logic [31:0] id_target;
    logic [31:0] br_cnt;
    logic [31:0] mispred_cnt;

    typedef struct {
        logic        f;
        logic [31:0] pc;
        logic [31:0] br;
        logic [31:0] mis;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] exp_br  = 0;
    logic [31:0] exp_mis = 0;

    branch_target_ctrl #(
        .ENTRIES  (16),
        .IDX_W    (4),
        .RESET_PC (32'h0)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .stall       (stall),
        .if_pc       (if_pc),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_pc       (id_pc),
        .id_is_cti   (id_is_cti),
        .id_taken    (id_taken),
        .id_target   (id_target),
        .br_cnt      (br_cnt),
        .mispred_cnt (mispred_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic void check(input string tag, input logic [31:0] obs,
                                  input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endfunction

    // One cycle: drive ID at negedge, check flush before the edge, then PC and counters after.
    task automatic step(input logic st, input logic v, input logic [31:0] pc,
                        input logic cti, input logic tk, input logic [31:0] tgt,
                        input logic ef, input logic [31:0] epc, input logic bi);
        exp_t e;
        @(negedge clk);
        stall     = st;
        id_valid  = v;
        id_pc     = pc;
        id_is_cti = cti;
        id_taken  = tk;
        id_target = tgt;
        if (!st) begin
            exp_br  = exp_br + 32'(bi);
            exp_mis = exp_mis + 32'(ef);
        end
        sb.push_back('{ef, epc, exp_br, exp_mis});
        #4;
        e = sb.pop_front();
        check("flush", 32'(flush), 32'(e.f));
        @(posedge clk);
        #1;
        check("if_pc", if_pc, e.pc);
        check("br_cnt", br_cnt, e.br);
        check("mispred_cnt", mispred_cnt, e.mis);
    endtask

    task automatic bubble(input logic [31:0] epc);
        step(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, epc, 1'b0);
    endtask

    initial begin
        rst_n     = 1'b0;
        stall     = 1'b0;
        id_valid  = 1'b0;
        id_pc     = '0;
        id_is_cti = 1'b0;
        id_taken  = 1'b0;
        id_target = '0;
        #6;
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_br_cnt", br_cnt, 32'h0);
        check("rst_mispred_cnt", mispred_cnt, 32'h0);
        #1 rst_n = 1'b1;

        // Sequential fetch with an empty ID stage.
        bubble(32'h4);
        bubble(32'h8);
        bubble(32'hC);
        bubble(32'h10);

        // Cold taken branch at 0x10 -> 0x40, then jump back from 0x40 to 0x10.
        step(1'b0, 1'b1, 32'hC,  1'b0, 1'b0, 32'h0,  1'b0, 32'h14, 1'b0);
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1);
        bubble(32'h44);
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1);
        // Both entries trained: the loop now predicts correctly.
        bubble(32'h40);
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h10, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h10, 1'b0, 32'h40, 1'b1);

        // Branch at 0x10 (ctr 11) now falls through twice: 11 -> 10 -> 01.
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1);
        bubble(32'h18);
        step(1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1);
        bubble(32'h40);
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b0, 32'h0,  1'b1, 32'h14, 1'b1);
        bubble(32'h10);
        step(1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10, 1'b0, 32'h14, 1'b1);

        // Pending mismatch held under a 3-cycle stall, resolved once.
        repeat (3) step(1'b1, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h14, 1'b0);
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b1, 32'h40, 1'b1);

        // Aliasing: 0x50 shares index 4 with 0x10 but misses.
        bubble(32'h10);
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h10, 1'b0, 32'h40, 1'b1);
        step(1'b0, 1'b1, 32'h10, 1'b1, 1'b1, 32'h40, 1'b0, 32'h10, 1'b1);
        step(1'b0, 1'b1, 32'h40, 1'b1, 1'b1, 32'h50, 1'b1, 32'h50, 1'b1);
        bubble(32'h54);
        step(1'b0, 1'b1, 32'h50, 1'b0, 1'b0, 32'h0,  1'b0, 32'h58, 1'b0);
        step(1'b0, 1'b1, 32'h54, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1);

        // Stale hit: 0x10 predicted taken but is now a non-CTI; entry must be dropped.
        bubble(32'h40);
        step(1'b0, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0,  1'b1, 32'h14, 1'b0);
        bubble(32'h18);
        step(1'b0, 1'b1, 32'h14, 1'b1, 1'b1, 32'h10, 1'b1, 32'h10, 1'b1);
        bubble(32'h14);

        // Reset during a stalled pending mismatch discards the redirect.
        @(negedge clk);
        stall     = 1'b1;
        id_valid  = 1'b1;
        id_pc     = 32'h10;
        id_is_cti = 1'b1;
        id_taken  = 1'b1;
        id_target = 32'h80;
        #1;
        check("stall_flush", 32'(flush), 32'h0);
        #1 rst_n = 1'b0;
        #1;
        check("midrst_if_pc", if_pc, 32'h0);
        check("midrst_flush", 32'(flush), 32'h0);
        check("midrst_br_cnt", br_cnt, 32'h0);
        check("midrst_mispred_cnt", mispred_cnt, 32'h0);
        #1 rst_n = 1'b1;
        exp_br  = 0;
        exp_mis = 0;
        bubble(32'h4);
        bubble(32'h8);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_target_ctrl.md
Name: branch_target_ctrl

Overview:
- Fetch-side branch controller for the 5-stage MIPS pipeline.
- Owns the IF-stage PC and predicts next PC from a direct-mapped branch target buffer (BTB) with 2-bit counters.
- Checks each prediction against the ID-stage branch resolution (taken flag and target from the branch unit). On mismatch it flushes the IF instruction and redirects fetch.
- PCs are instruction-memory relative: the 0x00400000 base is already removed, reset PC is 0.

Parameters:
ENTRIES, 16, number of BTB entries (power of two)
IDX_W, 4, log2(ENTRIES); index = pc[IDX_W+1:2], tag = pc[31:IDX_W+2]
RESET_PC, 32'h0, fetch PC after reset

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
stall  in  1  pipeline hold; IF/ID frozen this cycle
if_pc  out  32  current fetch address
flush  out  1  kill instruction currently in IF (combinational)
id_valid  in  1  ID holds a real (non-bubble) instruction
id_pc  in  32  PC of instruction in ID
id_is_cti  in  1  ID instruction is beq/bne/bgez/j/jal/jr/jalr
id_taken  in  1  branch unit: control transfer taken
id_target  in  32  branch unit: resolved target (valid when id_taken)
br_cnt  out  32  resolved CTIs counted
mispred_cnt  out  32  mispredictions counted

Behaviour:
- Reset (async, rst_n=0):
  - if_pc=RESET_PC; all entries valid=0, ctr=2'b01; prediction register cleared (pv=0).
  - br_cnt=0, mispred_cnt=0, flush=0.
- Lookup (combinational on if_pc):
  - hit = valid & tag match.
  - pred_taken = hit & ctr[1].
  - pred_next = pred_taken ? entry.target : if_pc+4 (32-bit wrap).
- Prediction register {pv, pnext}:
  - Loaded on each non-stalled edge with {1, pred_next} for the instruction moving IF->ID.
  - Loaded with pv=0 when flush=1, since the flushed slot becomes a bubble.
- Check (combinational):
  - actual_next = id_taken ? id_target : id_pc+4.
  - mispredict = !stall & id_valid & pv & (actual_next != pnext).
  - flush = mispredict.
- Next if_pc on each edge:
  - stall=1: hold.
  - else if mispredict: actual_next. Redirect has priority over the IF prediction.
  - else: pred_next.
- Table update (only when !stall & id_valid & pv); id index/tag taken from id_pc:
  - CTI, tag hit: ctr saturating +1 if id_taken, else saturating -1 (bounds 00/11). If taken, target <= id_target.
  - CTI, miss, taken: allocate/overwrite: valid=1, tag, target=id_target, ctr=2'b10.
  - CTI, miss, not taken: no write.
  - Non-CTI, tag hit (stale or aliased entry): valid <= 0.
- Same-cycle lookup and update of the same index: lookup sees pre-edge contents; the write takes effect at the edge.
- Counters:
  - br_cnt +1 per update cycle with id_is_cti.
  - mispred_cnt +1 per cycle with mispredict.
  - Both wrap modulo 2^32 and both are frozen under stall.
- Stall with a pending mismatch:
  - flush=0, no redirect, no table or counter change.
  - Mismatch is evaluated on the first non-stalled cycle, because ID inputs and pv are held.
- Reset mid-operation: pending redirect is discarded and fetch restarts at RESET_PC.
- No branch delay slots: on a taken redirect the IF instruction is always flushed.

Test Plan:
1. Reset, then id_valid=0 -> if_pc 0, 4, 8, 0xC on successive edges; flush=0; both counters 0.
2. Cold taken beq at 0x10 -> 0x40:
   - IF predicts 0x14.
   - In ID with id_taken=1: flush=1 for one cycle, next if_pc=0x40.
   - Entry idx 4 becomes valid with ctr=10, target 0x40; mispred_cnt=1, br_cnt=1.
3. Second fetch of 0x10 -> hit, next if_pc=0x40 directly; resolves taken -> flush=0, ctr=11, mispred_cnt unchanged, br_cnt=2.
4. Branch at 0x10 with ctr=11 now not taken:
   - Predicts 0x40 -> flush, if_pc=0x14, ctr=10.
   - Not taken again -> flush, ctr=01; next fetch of 0x10 predicts 0x14.
5. Mismatch in ID with stall=1 for 3 cycles -> flush=0 and if_pc held for all 3; first non-stall cycle gives flush=1 and redirect; mispred_cnt increments exactly once.
6. Aliasing and stale entries:
   - Entry for 0x10 is valid; fetch 0x50 (same idx 4, other tag) -> miss, predicts 0x54.
   - Stale hit on a non-CTI at 0x10 predicting 0x40 -> flush, redirect to 0x14, entry invalidated.
